// File: rtl/dct_uv_counter.sv
// Row-major (u, v) index sequencer for the 2-D DCT datapath.
// Steps over a BLOCK_SIZE x BLOCK_SIZE grid and holds a sticky done flag at the end.

module dct_uv_counter_ff_en #(
  parameter int unsigned     W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

module dct_uv_counter #(
  parameter int unsigned BLOCK_SIZE = 8,
  parameter int unsigned IDX_W      = $clog2(BLOCK_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             go,
  output logic [IDX_W-1:0] u,
  output logic [IDX_W-1:0] v,
  output logic             done,
  output logic             last
);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BLOCK_SIZE - 1);

  logic [IDX_W-1:0] u_q, u_d;
  logic [IDX_W-1:0] v_q, v_d;
  logic             done_q, done_d;
  logic             u_en, v_en, done_en;
  logic             adv;

  assign adv = go && !done_q;

  always_comb begin
    u_d     = u_q;
    v_d     = v_q;
    done_d  = done_q;
    u_en    = 1'b0;
    v_en    = 1'b0;
    done_en = 1'b0;
    if (restart) begin
      u_d     = '0;
      v_d     = '0;
      done_d  = 1'b0;
      u_en    = 1'b1;
      v_en    = 1'b1;
      done_en = 1'b1;
    end else if (adv) begin
      if (v_q != IDX_MAX) begin
        v_d  = v_q + IDX_W'(1);
        v_en = 1'b1;
      end else if (u_q != IDX_MAX) begin
        v_d  = '0;
        u_d  = u_q + IDX_W'(1);
        v_en = 1'b1;
        u_en = 1'b1;
      end else begin
        // Final pair: raise done and park on (MAX, MAX) instead of wrapping.
        done_d  = 1'b1;
        done_en = 1'b1;
      end
    end
  end

  dct_uv_counter_ff_en #(.W(IDX_W), .RST_VAL('0)) u_reg (
    .clk(clk), .rst(rst), .en(u_en), .d(u_d), .q(u_q)
  );

  dct_uv_counter_ff_en #(.W(IDX_W), .RST_VAL('0)) v_reg (
    .clk(clk), .rst(rst), .en(v_en), .d(v_d), .q(v_q)
  );

  dct_uv_counter_ff_en #(.W(1), .RST_VAL(1'b0)) done_reg (
    .clk(clk), .rst(rst), .en(done_en), .d(done_d), .q(done_q)
  );

  assign u    = u_q;
  assign v    = v_q;
  assign done = done_q;
  assign last = (u_q == IDX_MAX) && (v_q == IDX_MAX) && !done_q;
endmodule

// File: tb/tb_dct_uv_counter.sv
// Directed self-checking bench for dct_uv_counter at the default 8x8 grid.

module tb_dct_uv_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       restart = 1'b0;
  logic       go = 1'b0;
  logic [2:0] u, v;
  logic       done, last;

  int checks = 0;
  int failures = 0;

  dct_uv_counter #(.BLOCK_SIZE(8)) dut (
    .clk(clk), .rst(rst), .restart(restart), .go(go),
    .u(u), .v(v), .done(done), .last(last)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle outputs away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return to (0,0) and advance n go cycles (stimulus only).
  task automatic goto_index(input int n);
    restart = 1'b1; go = 1'b0;
    step();
    restart = 1'b0; go = 1'b1;
    for (int i = 0; i < n; i++) step();
    go = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b1;
    step();
    step();
    checks++;
    if ({u, v, done, last} !== {3'd0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: got u=%0d v=%0d done=%b last=%b, want u=0 v=0 done=0 last=0",
               u, v, done, last);
    end
    rst = 1'b0; go = 1'b0;
  endtask

  task automatic test_full_sweep();
    go = 1'b1;
    for (int k = 0; k < 64; k++) begin
      checks++;
      if ({u, v, done, last} !== {3'(k / 8), 3'(k % 8), 1'b0, (k == 63)}) begin
        failures++;
        $display("FAIL sweep[%0d]: got u=%0d v=%0d done=%b last=%b, want u=%0d v=%0d done=0 last=%b",
                 k, u, v, done, last, k / 8, k % 8, (k == 63));
      end
      step();
    end
    checks++;
    if ({u, v, done, last} !== {3'd7, 3'd7, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sweep_done: got u=%0d v=%0d done=%b last=%b, want u=7 v=7 done=1 last=0",
               u, v, done, last);
    end
  endtask

  task automatic test_go_while_done();
    go = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({u, v, done, last} !== {3'd7, 3'd7, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL go_while_done[%0d]: got u=%0d v=%0d done=%b last=%b, want u=7 v=7 done=1 last=0",
                 i, u, v, done, last);
      end
    end
  endtask

  task automatic test_restart_with_go();
    restart = 1'b1; go = 1'b1;
    step();
    checks++;
    if ({u, v, done} !== {3'd0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL restart_go: got u=%0d v=%0d done=%b, want u=0 v=0 done=0", u, v, done);
    end
    restart = 1'b0;
    step();
    checks++;
    if ({u, v, done} !== {3'd0, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL restart_next_go: got u=%0d v=%0d done=%b, want u=0 v=1 done=0", u, v, done);
    end
    go = 1'b0;
  endtask

  task automatic test_stall();
    logic       go_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0] v_exp  [4] = '{3'd6, 3'd6, 3'd6, 3'd7};
    goto_index(21);
    checks++;
    if ({u, v} !== {3'd2, 3'd5}) begin
      failures++;
      $display("FAIL stall_start: got u=%0d v=%0d, want u=2 v=5", u, v);
    end
    for (int i = 0; i < 4; i++) begin
      go = go_seq[i];
      step();
      checks++;
      if ({u, v, done} !== {3'd2, v_exp[i], 1'b0}) begin
        failures++;
        $display("FAIL stall[%0d]: got u=%0d v=%0d done=%b, want u=2 v=%0d done=0",
                 i, u, v, done, v_exp[i]);
      end
    end
    go = 1'b0;
  endtask

  task automatic test_row_wrap();
    goto_index(31);
    checks++;
    if ({u, v, last} !== {3'd3, 3'd7, 1'b0}) begin
      failures++;
      $display("FAIL wrap_start: got u=%0d v=%0d last=%b, want u=3 v=7 last=0", u, v, last);
    end
    go = 1'b1;
    step();
    checks++;
    if ({u, v} !== {3'd4, 3'd0}) begin
      failures++;
      $display("FAIL row_wrap: got u=%0d v=%0d, want u=4 v=0", u, v);
    end
    go = 1'b0;
  endtask

  task automatic test_reset_mid();
    goto_index(43);
    checks++;
    if ({u, v} !== {3'd5, 3'd3}) begin
      failures++;
      $display("FAIL mid_start: got u=%0d v=%0d, want u=5 v=3", u, v);
    end
    rst = 1'b1; go = 1'b1;
    step();
    checks++;
    if ({u, v, done} !== {3'd0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: got u=%0d v=%0d done=%b, want u=0 v=0 done=0", u, v, done);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({u, v} !== {3'd0, 3'd1}) begin
      failures++;
      $display("FAIL reset_mid_resume: got u=%0d v=%0d, want u=0 v=1", u, v);
    end
    go = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_go_while_done();
    test_restart_with_go();
    test_stall();
    test_row_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
